avst_packet_accum: RTL and testbench

Parametrised Avalon-ST packet accumulator: sums the data beats of each input packet (delimited by `end_in`) and emits per-packet results, or a running sum per beat, on an Avalon-ST output. Input and output widths, saturation and result buffering are configurable. It is the successor to the fixed 8-bit AVST adder and sits between a byte/word stream source and a result consumer, with full `valid`/`ready` backpressure on both sides.

---
 rtl/avst_packet_accum.sv | 116 +++++++++++
 tb/tb_avst_packet_accum.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avst_packet_accum.sv
// Avalon-ST packet accumulator: sums the beats of each packet (or emits a running
// sum per beat) and buffers results in a small show-ahead FIFO.
module avst_packet_accum #(
    parameter int DATA_W     = 8,
    parameter int SUM_W      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int SATURATE   = 0,
    parameter int RUNNING    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              end_in,
    input  logic              valid_in,
    output logic              ready_in,
    output logic [SUM_W-1:0]  data_out,
    output logic [15:0]       count_out,
    output logic              overflow_out,
    output logic              end_out,
    output logic              valid_out,
    input  logic              ready_out
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    // Handshake: a beat transfers on a rising edge with valid_in && ready_in, a
    // result on valid_out && ready_out. ready_in is a function of registered state
    // only, so space freed by a pop is offered from the following cycle.

    logic              run;
    logic [SUM_W-1:0]  acc;
    logic [15:0]       cnt;
    logic              ovf;

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       occ;

    logic [SUM_W-1:0]  mem_sum [FIFO_DEPTH];
    logic [15:0]       mem_cnt [FIFO_DEPTH];
    logic              mem_ovf [FIFO_DEPTH];
    logic              mem_end [FIFO_DEPTH];

    logic [SUM_W:0]    sum_full;
    logic              carry;
    logic [SUM_W-1:0]  acc_next;
    logic [15:0]       cnt_next;
    logic              ovf_next;
    logic              fifo_full;
    logic              accept;
    logic              push;
    logic              pop;

    assign fifo_full = (occ == (AW+1)'(FIFO_DEPTH));
    assign ready_in  = run && !fifo_full;
    assign valid_out = (occ != '0);

    assign accept = valid_in && ready_in;
    assign push   = accept && ((RUNNING != 0) || end_in);
    assign pop    = valid_out && ready_out;

    // Carry out of the extra top bit marks overflow of the SUM_W accumulator.
    assign sum_full = {1'b0, acc} + {{(SUM_W + 1 - DATA_W){1'b0}}, data_in};
    assign carry    = sum_full[SUM_W];
    assign acc_next = (carry && (SATURATE != 0)) ? {SUM_W{1'b1}} : sum_full[SUM_W-1:0];
    assign ovf_next = ovf | carry;
    assign cnt_next = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run    <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            run <= 1'b1;
            if (accept) begin
                if (end_in) begin
                    acc <= '0;
                    cnt <= '0;
                    ovf <= 1'b0;
                end else begin
                    acc <= acc_next;
                    cnt <= cnt_next;
                    ovf <= ovf_next;
                end
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Storage carries no reset; empty slots are masked at the outputs instead.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_sum[wr_ptr] <= acc_next;
            mem_cnt[wr_ptr] <= cnt_next;
            mem_ovf[wr_ptr] <= ovf_next;
            mem_end[wr_ptr] <= (RUNNING != 0) ? end_in : 1'b1;
        end
    end

    assign data_out     = valid_out ? mem_sum[rd_ptr] : '0;
    assign count_out    = valid_out ? mem_cnt[rd_ptr] : '0;
    assign overflow_out = valid_out ? mem_ovf[rd_ptr] : 1'b0;
    assign end_out      = valid_out ? mem_end[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_avst_packet_accum.sv
// Directed and randomised checks of avst_packet_accum across six configurations
// of SUM_W / SATURATE / RUNNING sharing one input stream.
module tb_avst_packet_accum;
  localparam int N = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] data_in = '0;
  logic end_in = 1'b0;
  logic valid_in = 1'b0;
  logic ready_out = 1'b0;

  logic [N-1:0] rdy_in;
  logic [N-1:0] vld_out;
  logic [N-1:0] ovf_out;
  logic [N-1:0] eop_out;
  logic [15:0] dout [N];
  logic [15:0] cout [N];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // g: 0 (16,wrap,pkt) 1 (8,wrap,pkt) 2 (8,sat,pkt) 3 (16,wrap,run) 4 (8,wrap,run) 5 (8,sat,run)
  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int SW  = (g == 0 || g == 3) ? 16 : 8;
    localparam int SAT = (g == 2 || g == 5) ? 1 : 0;
    localparam int RUN = (g >= 3) ? 1 : 0;
    logic [SW-1:0] d;
    avst_packet_accum #(
      .DATA_W(8), .SUM_W(SW), .FIFO_DEPTH(4), .SATURATE(SAT), .RUNNING(RUN)
    ) u_dut (
      .clk(clk),
      .reset(reset),
      .data_in(data_in),
      .end_in(end_in),
      .valid_in(valid_in),
      .ready_in(rdy_in[g]),
      .data_out(d),
      .count_out(cout[g]),
      .overflow_out(ovf_out[g]),
      .end_out(eop_out[g]),
      .valid_out(vld_out[g]),
      .ready_out(ready_out)
    );
    assign dout[g] = 16'(d);
  end

  function automatic int unsigned max_of(int g);
    return (g == 0 || g == 3) ? 32'd65535 : 32'd255;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    valid_in = 1'b0;
    end_in = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Present one beat at a negedge; returns at the following negedge.
  task automatic beat(input logic [7:0] d, input logic e);
    tests++;
    if (rdy_in !== {N{1'b1}}) begin
      fails++;
      $display("FAIL beat_ready: got %b want %b", rdy_in, {N{1'b1}});
    end
    data_in = d;
    end_in = e;
    valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    end_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ready_out = 1'b1;
    repeat (2) @(negedge clk);
    for (int g = 0; g < N; g++) begin
      tests++;
      if ({rdy_in[g], vld_out[g], dout[g], cout[g], ovf_out[g], eop_out[g]} !== 36'd0) begin
        fails++;
        $display("FAIL reset_outputs[%0d]: got %b %b %h %h %b %b want all zero", g,
                 rdy_in[g], vld_out[g], dout[g], cout[g], ovf_out[g], eop_out[g]);
      end
    end
    reset = 1'b1;
    #1;
    tests++;
    if (rdy_in !== '0) begin
      fails++;
      $display("FAIL ready_at_release: got %b want %b", rdy_in, {N{1'b0}});
    end
    @(negedge clk);
    tests++;
    if (rdy_in !== {N{1'b1}}) begin
      fails++;
      $display("FAIL ready_after_release: got %b want %b", rdy_in, {N{1'b1}});
    end
  endtask

  task automatic test_basic();
    ready_out = 1'b1;
    beat(8'h10, 1'b0);
    beat(8'h20, 1'b0);
    tests++;
    if (vld_out[2:0] !== 3'b000) begin
      fails++;
      $display("FAIL basic_no_early_result: got %b want 000", vld_out[2:0]);
    end
    beat(8'h30, 1'b1);
    for (int g = 0; g < N; g++) begin
      tests++;
      if ({vld_out[g], dout[g], cout[g], ovf_out[g], eop_out[g]} !== {1'b1, 16'h0060, 16'd3, 1'b0, 1'b1}) begin
        fails++;
        $display("FAIL basic_result[%0d]: got v=%b d=%h c=%0d o=%b e=%b want v=1 d=0060 c=3 o=0 e=1",
                 g, vld_out[g], dout[g], cout[g], ovf_out[g], eop_out[g]);
      end
    end
    @(negedge clk);
    tests++;
    if (vld_out !== '0) begin
      fails++;
      $display("FAIL basic_single_result: got %b want %b", vld_out, {N{1'b0}});
    end
  endtask

  task automatic test_wrap_saturate();
    logic [15:0] ed [N];
    logic [N-1:0] eo;
    ed = '{16'h0110, 16'h0010, 16'h00FF, 16'h0110, 16'h0010, 16'h00FF};
    eo = 6'b110110;
    do_reset();
    ready_out = 1'b1;
    beat(8'hF0, 1'b0);
    beat(8'h20, 1'b1);
    for (int g = 0; g < N; g++) begin
      tests++;
      if ({vld_out[g], dout[g], cout[g], ovf_out[g], eop_out[g]} !== {1'b1, ed[g], 16'd2, eo[g], 1'b1}) begin
        fails++;
        $display("FAIL wrap_sat[%0d]: got v=%b d=%h c=%0d o=%b e=%b want v=1 d=%h c=2 o=%b e=1",
                 g, vld_out[g], dout[g], cout[g], ovf_out[g], eop_out[g], ed[g], eo[g]);
      end
    end
    beat(8'h01, 1'b1);
    for (int g = 0; g < N; g++) begin
      tests++;
      if ({vld_out[g], dout[g], cout[g], ovf_out[g], eop_out[g]} !== {1'b1, 16'h0001, 16'd1, 1'b0, 1'b1}) begin
        fails++;
        $display("FAIL wrap_sat_next[%0d]: got v=%b d=%h c=%0d o=%b e=%b want v=1 d=0001 c=1 o=0 e=1",
                 g, vld_out[g], dout[g], cout[g], ovf_out[g], eop_out[g]);
      end
    end
  endtask

  task automatic test_running();
    logic [7:0] bd [4];
    logic [3:0] be;
    logic [15:0] ed [4];
    logic [15:0] ec [4];
    bd = '{8'd1, 8'd2, 8'd3, 8'd4};
    be = 4'b1100;
    ed = '{16'd1, 16'd3, 16'd6, 16'd4};
    ec = '{16'd1, 16'd2, 16'd3, 16'd1};
    do_reset();
    ready_out = 1'b1;
    for (int k = 0; k < 4; k++) begin
      beat(bd[k], be[k]);
      for (int g = 3; g < N; g++) begin
        tests++;
        if ({vld_out[g], dout[g], cout[g], ovf_out[g], eop_out[g]} !== {1'b1, ed[k], ec[k], 1'b0, be[k]}) begin
          fails++;
          $display("FAIL running[%0d] beat %0d: got v=%b d=%0d c=%0d o=%b e=%b want v=1 d=%0d c=%0d o=0 e=%b",
                   g, k, vld_out[g], dout[g], cout[g], ovf_out[g], eop_out[g], ed[k], ec[k], be[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int accepted;
    logic [15:0] es [4];
    es = '{16'd1, 16'd3, 16'd6, 16'd10};
    accepted = 0;
    do_reset();
    ready_out = 1'b0;
    for (int i = 0; i < 8; i++) begin
      data_in = 8'(i + 1);
      end_in = 1'b0;
      valid_in = 1'b1;
      if (rdy_in[3]) accepted++;
      @(posedge clk);
      @(negedge clk);
    end
    valid_in = 1'b0;
    tests++;
    if (accepted !== 4) begin
      fails++;
      $display("FAIL bp_accept_count: got %0d want 4", accepted);
    end
    for (int g = 3; g < N; g++) begin
      tests++;
      if ({rdy_in[g], vld_out[g], dout[g], cout[g], eop_out[g]} !== {1'b0, 1'b1, 16'd1, 16'd1, 1'b0}) begin
        fails++;
        $display("FAIL bp_stalled[%0d]: got r=%b v=%b d=%0d c=%0d e=%b want r=0 v=1 d=1 c=1 e=0",
                 g, rdy_in[g], vld_out[g], dout[g], cout[g], eop_out[g]);
      end
    end
    ready_out = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int g = 3; g < N; g++) begin
        tests++;
        if ({vld_out[g], dout[g], cout[g], eop_out[g]} !== {1'b1, es[k], 16'(k + 1), 1'b0}) begin
          fails++;
          $display("FAIL bp_drain[%0d] entry %0d: got v=%b d=%0d c=%0d e=%b want v=1 d=%0d c=%0d e=0",
                   g, k, vld_out[g], dout[g], cout[g], eop_out[g], es[k], k + 1);
        end
      end
      @(posedge clk);
      @(negedge clk);
      if (k == 0) begin
        tests++;
        if (rdy_in[5:3] !== 3'b111) begin
          fails++;
          $display("FAIL bp_ready_return: got %b want 111", rdy_in[5:3]);
        end
      end
    end
    tests++;
    if (vld_out[5:3] !== 3'b000) begin
      fails++;
      $display("FAIL bp_drained: got %b want 000", vld_out[5:3]);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    ready_out = 1'b0;
    beat(8'h05, 1'b0);
    beat(8'h06, 1'b0);
    reset = 1'b0;
    #1;
    tests++;
    if (vld_out !== '0) begin
      fails++;
      $display("FAIL midreset_valid: got %b want %b", vld_out, {N{1'b0}});
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    ready_out = 1'b1;
    beat(8'h07, 1'b1);
    for (int g = 0; g < N; g++) begin
      tests++;
      if ({vld_out[g], dout[g], cout[g], ovf_out[g], eop_out[g]} !== {1'b1, 16'h0007, 16'd1, 1'b0, 1'b1}) begin
        fails++;
        $display("FAIL midreset_result[%0d]: got v=%b d=%h c=%0d o=%b e=%b want v=1 d=0007 c=1 o=0 e=1",
                 g, vld_out[g], dout[g], cout[g], ovf_out[g], eop_out[g]);
      end
    end
  endtask

  task automatic test_random();
    logic [33:0] exp_q [N][$];
    int unsigned m_acc [N];
    int unsigned m_cnt [N];
    logic m_ovf [N];
    logic [33:0] e;
    int unsigned s;
    int pkts;
    int cyc;
    int drain;
    pkts = 0;
    cyc = 0;
    drain = 0;
    for (int g = 0; g < N; g++) begin
      m_acc[g] = 0;
      m_cnt[g] = 0;
      m_ovf[g] = 1'b0;
    end
    do_reset();
    while (drain < 12 && cyc < 40000) begin
      if (pkts < 1000) begin
        valid_in = ($urandom_range(0, 3) != 0);
        data_in = 8'($urandom_range(0, 255));
        end_in = ($urandom_range(0, 3) == 0);
        ready_out = ($urandom_range(0, 3) != 0);
        if (valid_in && end_in) pkts++;
      end else begin
        valid_in = 1'b0;
        end_in = 1'b0;
        ready_out = 1'b1;
        drain++;
      end
      for (int g = 0; g < N; g++) begin
        tests++;
        if ({vld_out[g], rdy_in[g]} !== {exp_q[g].size() != 0, exp_q[g].size() < 4}) begin
          fails++;
          $display("FAIL rand_flags[%0d] cyc %0d: got v=%b r=%b want v=%b r=%b", g, cyc,
                   vld_out[g], rdy_in[g], exp_q[g].size() != 0, exp_q[g].size() < 4);
        end
        if (vld_out[g] && ready_out && exp_q[g].size() != 0) begin
          e = exp_q[g].pop_front();
          tests++;
          if ({dout[g], cout[g], ovf_out[g], eop_out[g]} !== e) begin
            fails++;
            $display("FAIL rand_result[%0d] cyc %0d: got d=%h c=%0d o=%b e=%b want d=%h c=%0d o=%b e=%b",
                     g, cyc, dout[g], cout[g], ovf_out[g], eop_out[g], e[33:18], e[17:2], e[1], e[0]);
          end
        end
        if (valid_in && rdy_in[g]) begin
          s = m_acc[g] + 32'(data_in);
          if (s > max_of(g)) begin
            m_ovf[g] = 1'b1;
            s = (g == 2 || g == 5) ? max_of(g) : s - (max_of(g) + 1);
          end
          m_acc[g] = s;
          if (m_cnt[g] != 65535) m_cnt[g]++;
          if (g >= 3 || end_in)
            exp_q[g].push_back({16'(m_acc[g]), 16'(m_cnt[g]), m_ovf[g], end_in});
          if (end_in) begin
            m_acc[g] = 0;
            m_cnt[g] = 0;
            m_ovf[g] = 1'b0;
          end
        end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (drain < 12) begin
      fails++;
      $display("FAIL rand_timeout: got %0d cycles want completion below 40000", cyc);
    end
    for (int g = 0; g < N; g++) begin
      tests++;
      if (exp_q[g].size() != 0 || vld_out[g] !== 1'b0) begin
        fails++;
        $display("FAIL rand_leftover[%0d]: got %0d pending v=%b want 0 pending v=0", g,
                 exp_q[g].size(), vld_out[g]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap_saturate();
    test_running();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
